// File: rtl/digit_serial_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/digit_serial_addsub_slice.sv
// SLICE-bit combinational ripple add/sub digit; exposes the carry into the MSB
// so the caller can form signed overflow on the last digit.
module addsub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ctrl,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE:0]   c;
  logic [SLICE-1:0] bx;

  always_comb begin
    bx = b ^ {SLICE{ctrl}};
    c  = '0;
    s  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
    end
    cout     = c[SLICE];
    c_msb_in = c[SLICE-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Wide add/sub computed one SLICE-bit digit per clock, LSB first, through a
// single narrow slice; valid/ready request and response handshakes.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state_q;
  logic [CW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             ctrl_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, ovf_q, zero_q;
  logic             res_valid_q, start_ready_q;

  logic [SLICE-1:0] dig_s;
  logic             dig_c, dig_cmsb;
  logic             accept, last;

  assign accept = (state_q == IDLE) && start_valid && start_ready_q;
  assign last   = (idx_q == CW'(NSLICE - 1));

  // Operands shift right each RUN cycle, so the active digit is always at the bottom.
  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a        (a_q[SLICE-1:0]),
    .b        (b_q[SLICE-1:0]),
    .ctrl     (ctrl_q),
    .cin      (carry_q),
    .s        (dig_s),
    .cout     (dig_c),
    .c_msb_in (dig_cmsb)
  );

  always_comb begin
    sum_d = sum_q;
    sum_d[int'(idx_q)*SLICE +: SLICE] = dig_s;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= a;
      b_q    <= b;
      ctrl_q <= ctrl;
    end else if (state_q == RUN) begin
      a_q <= a_q >> SLICE;
      b_q <= b_q >> SLICE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      zero_q        <= 1'b0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            carry_q       <= (ctrl == OP_SUB);
            idx_q         <= '0;
            start_ready_q <= 1'b0;
            state_q       <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= dig_c;
          if (last) begin
            cout_q      <= dig_c;
            ovf_q       <= dig_cmsb ^ dig_c;
            zero_q      <= (sum_d == '0);
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          start_ready_q <= 1'b1;
          res_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed and randomized checks of digit_serial_addsub against an arithmetic model.
module tb_digit_serial_addsub;

  localparam int W = 16;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         ctrl = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  int tests = 0;
  int fails = 0;

  digit_serial_addsub #(.WIDTH(W), .SLICE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .ctrl        (ctrl),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain two's-complement arithmetic reference.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       output logic [W-1:0] es, output logic ec, output logic eo, output logic ez);
    int signed sa, sb, sr;
    logic [W:0] full;
    full = tc ? ({1'b0, ta} + {1'b0, ~tb} + 17'd1) : ({1'b0, ta} + {1'b0, tb});
    es = full[W-1:0];
    ec = full[W];
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    sr = tc ? (sa - sb) : (sa + sb);
    eo = (sr > 32767) || (sr < -32768);
    ez = (es == '0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input bit churn, input bit hold5);
    logic [W-1:0] es;
    logic ec, eo, ez;
    int n;
    model(ta, tb, tc, es, ec, eo, ez);
    n = 0;
    while (!start_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_op", start_ready, 1);
    a = ta; b = tb; ctrl = tc; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("ready_low_in_run", start_ready, 0);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (churn) begin a = W'($urandom); b = W'($urandom); ctrl = 1'($urandom); end
    end while (!res_valid && n < 20);
    check("latency", n, NS);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    check("zero", zero, ez);
    if (hold5) begin
      start_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        a = W'($urandom);
        @(posedge clk); #1;
        check("hold_valid", res_valid, 1);
        check("hold_sum", sum, es);
        check("hold_flags", {cout, ovf, zero}, {ec, eo, ez});
        check("hold_ready_low", start_ready, 0);
      end
      start_valid = 1'b0;
    end
    if (res_ready) begin
      @(posedge clk); #1;
      check("one_cycle_valid", res_valid, 0);
    end else begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("release_valid", res_valid, 0);
      check("release_ready", start_ready, 1);
    end
  endtask

  initial begin
    #12;
    check("rst_ready", start_ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_outs", {sum, cout, ovf, zero}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 0, 0);
    check("add_direct", sum, 16'h2233);
    run_op(16'h0005, 16'h0003, 1'b1, 0, 0);
    check("sub_pos", {sum, cout}, {16'h0002, 1'b1});
    run_op(16'h0003, 16'h0005, 1'b1, 0, 0);
    check("sub_neg", {sum, cout, ovf}, {16'hFFFE, 1'b0, 1'b0});
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0);
    check("add_ovf", {sum, ovf, cout}, {16'h8000, 1'b1, 1'b0});
    run_op(16'h8000, 16'h0001, 1'b1, 0, 0);
    check("sub_ovf", {sum, ovf}, {16'h7FFF, 1'b1});
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0);
    check("add_zero", {sum, cout, zero, ovf}, {16'h0000, 1'b1, 1'b1, 1'b0});

    run_op(16'h4321, 16'h1111, 1'b1, 0, 1);
    @(posedge clk); #1;
    check("no_accept_after_hold", res_valid, 0);
    check("idle_after_hold", start_ready, 1);

    run_op(16'h00FF, 16'h0001, 1'b0, 1, 0);
    check("churn_sum", sum, 16'h0100);

    res_ready = 1'b1;
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 0, 0);
    res_ready = 1'b0;

    a = 16'h1111; b = 16'h2222; ctrl = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("midrun_valid", res_valid, 0);
    check("midrun_ready", start_ready, 1);
    check("midrun_sum", sum, 16'h0000);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0001, 1'b0, 0, 0);
    check("after_reset_sum", sum, 16'h0002);

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), (i % 3) == 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
